// File: rtl/diff_frame_wr.sv
// Frame writer: packs 8-lane diff-stage beats into RAM words and writes whole
// frames into a ping-pong frame RAM. A frame is dropped whole if its bank is still busy.

module diff_frame_wr_lane #(
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic [LW-1:0] d,
  output logic [LW-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
endmodule

module diff_frame_wr #(
  parameter  int SAMPLE_WIDTH = 32,
  parameter  int BURST_LEN    = 8,
  parameter  int DATA_NUM     = 1024,
  parameter  int RAM_WIDTH    = 128,
  localparam int LANE_W       = SAMPLE_WIDTH/2,
  localparam int WORDS        = DATA_NUM/BURST_LEN,
  localparam int ADDR_W       = $clog2(WORDS)+1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [LANE_W-1:0] i_y0 [BURST_LEN],
  input  logic                     i_y0_valid,
  input  logic                     i_rd_done,
  input  logic                     i_rd_bank,
  input  logic                     i_clr_ovf,
  output logic                     o_wr_en,
  output logic [ADDR_W-1:0]        o_wr_addr,
  output logic [RAM_WIDTH-1:0]     o_wr_data,
  output logic                     o_frame_done,
  output logic                     o_frame_bank,
  output logic [1:0]               o_bank_full,
  output logic                     o_ovf
);
  localparam int CNT_W = ADDR_W-1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS-1);

  typedef enum logic {WRITE = 1'b0, DROP = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] wcnt;
  logic             wb;
  logic [1:0]       rel, set, full_eff;
  logic             frame_start, wr_ok, wr_fire, last_beat;

  logic [BURST_LEN-1:0][LANE_W-1:0] lane_q;

  // The write/drop decision sees this cycle's release, so a bank freed on the
  // first beat of a frame is already usable for that frame.
  always_comb begin
    rel = '0;
    set = '0;
    if (i_rd_done) rel[i_rd_bank] = 1'b1;
    full_eff    = o_bank_full & ~rel;
    frame_start = i_y0_valid && (wcnt == '0);
    wr_ok       = frame_start ? !full_eff[wb] : (state == WRITE);
    wr_fire     = i_y0_valid && wr_ok;
    last_beat   = wr_fire && (wcnt == LAST);
    if (last_beat) set[wb] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WRITE;
      wcnt         <= '0;
      wb           <= 1'b0;
      o_bank_full  <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_frame_done <= 1'b0;
      o_frame_bank <= 1'b0;
      o_ovf        <= 1'b0;
    end else begin
      o_wr_en      <= wr_fire;
      o_frame_done <= last_beat;
      if (wr_fire)     o_wr_addr <= {wb, wcnt};
      if (frame_start) state     <= wr_ok ? WRITE : DROP;
      if (i_y0_valid)  wcnt      <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
      if (last_beat) begin
        wb           <= ~wb;
        o_frame_bank <= wb;
      end
      // set is applied after clear so a same-bank collision leaves the bank full
      o_bank_full <= full_eff | set;
      if (frame_start && !wr_ok) o_ovf <= 1'b1;
      else if (i_clr_ovf)        o_ovf <= 1'b0;
    end
  end

  for (genvar k = 0; k < BURST_LEN; k++) begin : g_lane
    diff_frame_wr_lane #(.LW(LANE_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (wr_fire),
      .d     (i_y0[k]),
      .q     (lane_q[k])
    );
  end

  assign o_wr_data = lane_q;

endmodule

// File: tb/tb_diff_frame_wr.sv
// Bench for diff_frame_wr: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_diff_frame_wr;
  localparam int WORDS = 128;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic signed [15:0] y0 [8];
  logic              y0_valid = 1'b0, rd_done = 1'b0, rd_bank = 1'b0, clr_ovf = 1'b0;
  logic              wr_en, frame_done, frame_bank, ovf;
  logic [7:0]        wr_addr;
  logic [127:0]      wr_data;
  logic [1:0]        bank_full;

  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  diff_frame_wr dut (
    .clk(clk), .rst_n(rst_n), .i_y0(y0), .i_y0_valid(y0_valid),
    .i_rd_done(rd_done), .i_rd_bank(rd_bank), .i_clr_ovf(clr_ovf),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_frame_done(frame_done), .o_frame_bank(frame_bank),
    .o_bank_full(bank_full), .o_ovf(ovf)
  );

  // Reference model: frame position, bank occupancy, write bank, drop mode.
  logic         e_en, e_done, e_fbank, e_ovf, m_wb, m_drop;
  logic [7:0]   e_addr;
  logic [127:0] e_data;
  logic [1:0]   m_full;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin : model
    logic [1:0]   f;
    logic         drop, ovf_n;
    logic [127:0] d;
    if (!rst_n) begin
      e_en <= 0; e_done <= 0; e_fbank <= 0; e_ovf <= 0; e_addr <= 0; e_data <= 0;
      m_wb <= 0; m_drop <= 0; m_full <= 0; m_cnt <= 0;
    end else begin
      f = m_full;
      if (rd_done) f[rd_bank] = 1'b0;
      drop  = m_drop;
      ovf_n = clr_ovf ? 1'b0 : e_ovf;
      for (int k = 0; k < 8; k++) d[16*k +: 16] = y0[k];
      e_en   <= 1'b0;
      e_done <= 1'b0;
      if (y0_valid) begin
        if (m_cnt == 0) begin
          drop = f[m_wb];
          if (drop) ovf_n = 1'b1;
        end
        if (!drop) begin
          e_en   <= 1'b1;
          e_addr <= 8'(m_wb * WORDS + m_cnt);
          e_data <= d;
          if (m_cnt == WORDS-1) begin
            f[m_wb] = 1'b1;
            e_done  <= 1'b1;
            e_fbank <= m_wb;
            m_wb    <= ~m_wb;
          end
        end
        m_cnt  <= (m_cnt + 1) % WORDS;
        m_drop <= drop;
      end
      m_full <= f;
      e_ovf  <= ovf_n;
    end
  end

  // Write log used by the directed checks.
  int           wr_total = 0, done_total = 0, wr_at_done = 0, brk = 0;
  logic         done_bank_last = 1'b0;
  logic [7:0]   last_addr = 0, first_addr = 0, prev_addr = 0;
  logic [127:0] last_data = 0, w0_data = 0;

  always @(negedge clk) if (rst_n) begin
    if (wr_en) begin
      if (wr_addr[6:0] == 7'd0) begin
        first_addr <= wr_addr;
        w0_data    <= wr_data;
      end else if (wr_addr != prev_addr + 8'd1) brk <= brk + 1;
      prev_addr <= wr_addr;
      last_addr <= wr_addr;
      last_data <= wr_data;
      wr_total  <= wr_total + 1;
    end
    if (frame_done) begin
      done_total     <= done_total + 1;
      done_bank_last <= frame_bank;
      wr_at_done     <= wr_total + (wr_en ? 1 : 0);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input bit v, input int n, input bit rd, input bit rb);
    y0_valid = v; rd_done = rd; rd_bank = rb;
    for (int k = 0; k < 8; k++) y0[k] = 16'(n*8 + k);
    tick();
    y0_valid = 1'b0; rd_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 0, 0, 0);
  endtask

  task automatic send_frame(input int from, input bit gap, input bit rd_first);
    for (int n = from; n < WORDS; n++) begin
      beat(1, n, rd_first && n == 0, 1'b0);
      if (gap) beat(0, n, 0, 0);
    end
  endtask

  int s_wr, s_done, s_brk;

  task automatic snap();
    s_wr = wr_total; s_done = done_total; s_brk = brk;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) y0[k] = '0;
    fork
      forever begin
        @(negedge clk);
        if (chk_on) begin
          total++;
          if (wr_en !== e_en || (e_en && (wr_addr !== e_addr || wr_data !== e_data)) ||
              frame_done !== e_done || (e_done && frame_bank !== e_fbank) ||
              bank_full !== m_full || ovf !== e_ovf) begin
            bad++;
            $display("FAIL cycle t=%0t en=%b/%b addr=%0h/%0h data=%0h/%0h done=%b/%b bank=%b/%b full=%b/%b ovf=%b/%b",
                     $time, wr_en, e_en, wr_addr, e_addr, wr_data, e_data, frame_done, e_done,
                     frame_bank, e_fbank, bank_full, m_full, ovf, e_ovf);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_full", bank_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1'b1;
    idle(2);

    // frame 1 -> bank 0
    snap();
    send_frame(0, 0, 0);
    idle(2);
    chk("f1_writes", wr_total - s_wr, 128);
    chk("f1_done_cnt", done_total - s_done, 1);
    chk("f1_done_at", wr_at_done - s_wr, 128);
    chk("f1_bank", done_bank_last, 0);
    chk("f1_first", first_addr, 0);
    chk("f1_last", last_addr, 127);
    chk("f1_contig", brk - s_brk, 0);
    chk("f1_word0", w0_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("f1_full", bank_full, 2'b01);

    // frame 2 -> bank 1
    snap();
    send_frame(0, 0, 0);
    idle(2);
    chk("f2_writes", wr_total - s_wr, 128);
    chk("f2_first", first_addr, 128);
    chk("f2_last", last_addr, 255);
    chk("f2_bank", done_bank_last, 1);
    chk("f2_full", bank_full, 2'b11);
    chk("f2_ovf", ovf, 0);

    // frame 3 -> dropped
    snap();
    beat(1, 0, 0, 0);
    chk("f3_ovf_first", ovf, 1);
    send_frame(1, 0, 0);
    idle(2);
    chk("f3_writes", wr_total - s_wr, 0);
    chk("f3_done_cnt", done_total - s_done, 0);
    chk("f3_full", bank_full, 2'b11);

    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; tick();
    chk("clr_ovf", ovf, 0);

    // release bank 0 on the first beat of the next frame
    snap();
    send_frame(0, 0, 1);
    idle(2);
    chk("f4_writes", wr_total - s_wr, 128);
    chk("f4_first", first_addr, 0);
    chk("f4_last", last_addr, 127);
    chk("f4_bank", done_bank_last, 0);
    chk("f4_ovf", ovf, 0);
    chk("f4_full", bank_full, 2'b11);

    // releases, including one of an already-empty bank
    beat(0, 0, 1, 0); idle(1);
    beat(0, 0, 1, 0); idle(1);
    chk("rel0_full", bank_full, 2'b10);
    beat(0, 0, 1, 1); idle(1);
    chk("rel1_full", bank_full, 2'b00);

    // 1-0-1-0 valid pattern into bank 1
    snap();
    send_frame(0, 1, 0);
    idle(2);
    chk("gap_writes", wr_total - s_wr, 128);
    chk("gap_done_cnt", done_total - s_done, 1);
    chk("gap_contig", brk - s_brk, 0);
    chk("gap_first", first_addr, 128);
    chk("gap_last", last_addr, 255);
    chk("gap_bank", done_bank_last, 1);
    chk("gap_full", bank_full, 2'b10);

    // reset after 50 beats of a bank-0 frame
    for (int n = 0; n < 50; n++) beat(1, n, 0, 0);
    rst_n = 1'b0;
    idle(3);
    chk("mid_rst_full", bank_full, 2'b00);
    chk("mid_rst_wr_en", wr_en, 0);
    rst_n = 1'b1;
    idle(1);
    snap();
    send_frame(0, 0, 0);
    idle(2);
    chk("rf_done_cnt", done_total - s_done, 1);
    chk("rf_done_at", wr_at_done - s_wr, 128);
    chk("rf_first", first_addr, 0);
    chk("rf_last", last_addr, 127);
    chk("rf_bank", done_bank_last, 0);
    chk("rf_full", bank_full, 2'b01);

    // negative samples, written to bank 1 word 0
    for (int k = 0; k < 8; k++) y0[k] = 16'(k);
    y0[0] = -16'sd1;
    y0[7] = -16'sd32768;
    y0_valid = 1'b1;
    tick();
    y0_valid = 1'b0;
    idle(2);
    chk("neg_addr", last_addr, 128);
    chk("neg_lane0", last_data[15:0], 16'hFFFF);
    chk("neg_lane1", last_data[31:16], 16'h0001);
    chk("neg_lane7", last_data[127:112], 16'h8000);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

endmodule
